// File: rtl/i2c_temp_responder_pkg.sv
// Shared types and constants for the I2C temperature-sensor responder.
package i2c_temp_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_IGNORE
  } state_t;

  localparam logic [7:0] PTR_TEMP_MSB = 8'h00;
  localparam logic [7:0] PTR_TEMP_LSB = 8'h01;
  localparam logic [7:0] PTR_ID       = 8'h0B;

  localparam logic [6:0] DEF_DEV_ADDR = 7'h4B;
  localparam logic [7:0] DEF_ID_VALUE = 8'hCB;

  function automatic logic [7:0] reg_byte(input logic [7:0]  ptr,
                                          input logic [15:0] word,
                                          input logic [7:0]  id);
    case (ptr)
      PTR_TEMP_MSB: return word[15:8];
      PTR_TEMP_LSB: return word[7:0];
      PTR_ID:       return id;
      default:      return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA conditioning: 2-flop synchronizers, optional 3-sample majority filter
// (enabled by I2C_GLITCH_FILTER_EN), and SCL edge / START / STOP detection.
module i2c_line_cond (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [1:0] r_scl_sync, r_sda_sync;
  logic       w_scl, w_sda;
  logic       r_scl_d, r_sda_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], i_scl};
      r_sda_sync <= {r_sda_sync[0], i_sda};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [1:0] r_scl_hist, r_sda_hist;
  logic       r_scl_filt, r_sda_filt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scl_hist <= '1;
      r_sda_hist <= '1;
      r_scl_filt <= 1'b1;
      r_sda_filt <= 1'b1;
    end else begin
      r_scl_hist <= {r_scl_hist[0], r_scl_sync[1]};
      r_sda_hist <= {r_sda_hist[0], r_sda_sync[1]};
      r_scl_filt <= (r_scl_sync[1] & r_scl_hist[0]) | (r_scl_sync[1] & r_scl_hist[1]) |
                    (r_scl_hist[0] & r_scl_hist[1]);
      r_sda_filt <= (r_sda_sync[1] & r_sda_hist[0]) | (r_sda_sync[1] & r_sda_hist[1]) |
                    (r_sda_hist[0] & r_sda_hist[1]);
    end
  end

  assign w_scl = r_scl_filt;
  assign w_sda = r_sda_filt;
`else
  assign w_scl = r_scl_sync[1];
  assign w_sda = r_sda_sync[1];
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
    end
  end

  assign o_sda      = w_sda;
  assign o_scl_rise = w_scl & ~r_scl_d;
  assign o_scl_fall = ~w_scl & r_scl_d;
  assign o_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign o_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

endmodule

// File: rtl/i2c_temp_responder.sv
// I2C target emulating the temperature sensor: pointer write, MSB/LSB/ID reads,
// open-drain SDA pull with a fixed hold delay after each SCL fall.
module i2c_temp_responder
  import i2c_temp_responder_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = DEF_DEV_ADDR,
  parameter logic [7:0]  ID_VALUE = DEF_ID_VALUE,
  parameter int unsigned HOLD_CYC = 30
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_pull,
  input  logic [15:0] temp_in,
  output logic        busy,
  output logic        rd_done
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYC + 1);

  logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  i2c_line_cond u_line_cond (
    .i_clk      (clk),
    .i_rst_n    (reset_n),
    .i_scl      (scl_in),
    .i_sda      (sda_in),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  state_t              r_state, w_state_nxt;
  logic [3:0]          r_bitcnt;
  logic [6:0]          r_shift;
  logic [7:0]          r_tx, r_ptr;
  logic [15:0]         r_shadow;
  logic                r_rw, r_first, r_busy, r_rd_done, r_pull, r_hold_act;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [7:0]          w_rx_byte;
  logic                w_addr_match, w_pull_want;

  assign w_rx_byte    = {r_shift, w_sda};
  assign w_addr_match = (w_rx_byte[7:1] == DEV_ADDR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // ACK states are entered on the 8th rise, so they leave on the fall after the 9th rise.
  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = ST_ADDR;
    end else if (w_stop) begin
      w_state_nxt = ST_IDLE;
    end else if (w_scl_rise) begin
      case (r_state)
        ST_ADDR:    if (r_bitcnt == 4'd7) w_state_nxt = w_addr_match ? ST_ADDR_ACK : ST_IGNORE;
        ST_WR_BYTE: if (r_bitcnt == 4'd7) w_state_nxt = ST_WR_ACK;
        ST_RD_ACK:  if (w_sda) w_state_nxt = ST_IGNORE;
        default:    ;
      endcase
    end else if (w_scl_fall) begin
      case (r_state)
        ST_ADDR_ACK: if (r_bitcnt == 4'd9) w_state_nxt = r_rw ? ST_RD_BYTE : ST_WR_BYTE;
        ST_WR_ACK:   if (r_bitcnt == 4'd9) w_state_nxt = ST_WR_BYTE;
        ST_RD_BYTE:  if (r_bitcnt == 4'd8) w_state_nxt = ST_RD_ACK;
        ST_RD_ACK:   w_state_nxt = ST_RD_BYTE;
        default:     ;
      endcase
    end
  end

  always_comb begin
    w_pull_want = 1'b0;
    case (r_state)
      ST_ADDR_ACK, ST_WR_ACK: w_pull_want = 1'b1;
      ST_RD_BYTE:             w_pull_want = ~r_tx[7];
      default:                w_pull_want = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_tx       <= '0;
      r_ptr      <= '0;
      r_shadow   <= '0;
      r_rw       <= 1'b0;
      r_first    <= 1'b0;
      r_busy     <= 1'b0;
      r_rd_done  <= 1'b0;
      r_pull     <= 1'b0;
      r_hold_act <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      r_rd_done <= 1'b0;
      if (w_start) begin
        r_bitcnt   <= '0;
        r_pull     <= 1'b0;
        r_hold_act <= 1'b0;
      end else if (w_stop) begin
        r_pull     <= 1'b0;
        r_hold_act <= 1'b0;
        r_busy     <= 1'b0;
      end else begin
        if (w_scl_rise) begin
          case (r_state)
            ST_ADDR: begin
              r_shift  <= w_rx_byte[6:0];
              r_bitcnt <= r_bitcnt + 4'd1;
              if (r_bitcnt == 4'd7) begin
                r_rw    <= w_rx_byte[0];
                r_first <= 1'b1;
                r_busy  <= w_addr_match;
              end
            end
            ST_WR_BYTE: begin
              r_shift  <= w_rx_byte[6:0];
              r_bitcnt <= r_bitcnt + 4'd1;
              if (r_bitcnt == 4'd7 && r_first) begin
                r_ptr   <= w_rx_byte;
                r_first <= 1'b0;
              end
            end
            ST_ADDR_ACK, ST_WR_ACK, ST_RD_BYTE: r_bitcnt <= r_bitcnt + 4'd1;
            ST_RD_ACK: begin
              r_ptr <= r_ptr + 8'd1;
              if (w_sda) begin
                r_rd_done <= 1'b1;
                r_busy    <= 1'b0;
              end
            end
            default: ;
          endcase
        end

        if (w_scl_fall) begin
          r_hold_act <= 1'b1;
          r_hold_cnt <= HOLD_W'(HOLD_CYC - 1);
          case (r_state)
            ST_ADDR_ACK: if (r_bitcnt == 4'd9) begin
              r_bitcnt <= '0;
              if (r_rw) begin
                r_shadow <= temp_in;
                r_tx     <= reg_byte(r_ptr, temp_in, ID_VALUE);
              end
            end
            ST_WR_ACK: if (r_bitcnt == 4'd9) r_bitcnt <= '0;
            ST_RD_BYTE: begin
              if (r_bitcnt == 4'd8) r_bitcnt <= '0;
              else                  r_tx     <= {r_tx[6:0], 1'b0};
            end
            ST_RD_ACK: begin
              r_bitcnt <= '0;
              r_tx     <= reg_byte(r_ptr, r_shadow, ID_VALUE);
            end
            default: ;
          endcase
        end else if (r_hold_act) begin
          if (r_hold_cnt == '0) begin
            r_hold_act <= 1'b0;
            r_pull     <= w_pull_want;
          end else begin
            r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
          end
        end
      end
    end
  end

  assign sda_pull = r_pull;
  assign busy     = r_busy;
  assign rd_done  = r_rd_done;

endmodule
